// File: rtl/seq_conv_encoder_punct_if.sv
// Bit-in / coded-symbol-out bus of seq_conv_encoder_punct.
// master = bit source and symbol sink, slave = encoder.
interface seq_conv_encoder_punct_if #(
  parameter int FRAME_W = 16
);
  logic [1:0]         i_code_rate;
  logic               i_diff_en;
  logic [FRAME_W-1:0] i_frame_len;
  logic               i_vld;
  logic               i_data;
  logic               o_rdy;
  logic               o_vld;
  logic               o_sys;
  logic               o_par;
  logic               o_par_keep;
  logic               o_sof;
  logic               o_eof;

  modport master (
    output i_code_rate, i_diff_en, i_frame_len, i_vld, i_data,
    input  o_rdy, o_vld, o_sys, o_par, o_par_keep, o_sof, o_eof
  );

  modport slave (
    input  i_code_rate, i_diff_en, i_frame_len, i_vld, i_data,
    output o_rdy, o_vld, o_sys, o_par, o_par_keep, o_sof, o_eof
  );
endinterface

// File: rtl/seq_conv_encoder_punct.sv
// Frame-based systematic convolutional encoder with zero-tail termination and puncturing.
// Latency: clog2(K)+2 cycles from the accept (or tail-inject) edge to o_vld.
// Backpressure: none from downstream; o_rdy drops only for the K-1 cycle tail.
module seq_conv_encoder_punct #(
  parameter int           K       = 89,
  parameter logic [K-1:0] POLY    = 89'hD354E3267,
  parameter int           FRAME_W = 16
) (
  input logic                     clk,
  input logic                     reset_n,
  seq_conv_encoder_punct_if.slave bus
);

  localparam int D = $clog2(K);
  localparam int W = 1 << D;

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  typedef struct packed {
    logic vld;
    logic sys;
    logic sof;
    logic eof;
    logic keep;
  } side_t;

  function automatic logic [2:0] last_phase(input logic [1:0] rate);
    case (rate)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd2;
      default: return 3'd6;
    endcase
  endfunction

  state_t             state;
  logic               rdy_q;
  logic [FRAME_W-1:0] cnt;
  logic [FRAME_W-1:0] len_q;
  logic [1:0]         rate_q;
  logic               diff_q;
  logic               prev_d;
  logic [2:0]         pcnt;
  logic [D-1:0]       tail_cnt;

  logic in_vld, in_d, in_sof, in_eof, in_keep;

  logic               accept, start, in_tail, tail_last, sym;
  logic               d_now, keep_now, phase_wrap;
  logic [1:0]         rate_use;
  logic [2:0]         phase;
  logic               prev_use, diff_use;
  logic [FRAME_W-1:0] len_eff;

  logic [K-2:0]   sr;
  logic [K-1:0]   v;
  logic [2*W-2:0] tree;
  side_t          side [0:D];

  assign accept    = bus.i_vld & rdy_q;
  assign bus.o_rdy = rdy_q;

  always_comb begin
    start      = accept && (state == IDLE);
    len_eff    = (bus.i_frame_len == '0) ? FRAME_W'(1) : bus.i_frame_len;
    rate_use   = start ? bus.i_code_rate : rate_q;
    phase      = start ? 3'd0 : pcnt;
    prev_use   = start ? 1'b0 : prev_d;
    diff_use   = start ? bus.i_diff_en : diff_q;
    in_tail    = (state == TAIL);
    tail_last  = in_tail && (tail_cnt == D'(K-2));
    sym        = accept || in_tail;
    // tail bits bypass the pre-coder so the register flushes with raw zeros
    d_now      = in_tail ? 1'b0 : (bus.i_data ^ (diff_use & prev_use));
    phase_wrap = (phase == last_phase(rate_use));
    keep_now   = phase_wrap || tail_last;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      rdy_q    <= 1'b0;
      cnt      <= '0;
      len_q    <= '0;
      rate_q   <= '0;
      diff_q   <= 1'b0;
      prev_d   <= 1'b0;
      pcnt     <= '0;
      tail_cnt <= '0;
      in_vld   <= 1'b0;
      in_d     <= 1'b0;
      in_sof   <= 1'b0;
      in_eof   <= 1'b0;
      in_keep  <= 1'b0;
    end else begin
      in_vld  <= sym;
      in_d    <= d_now;
      in_sof  <= start;
      in_eof  <= tail_last;
      in_keep <= keep_now;
      if (sym) pcnt <= phase_wrap ? 3'd0 : phase + 3'd1;
      if (accept) prev_d <= d_now;
      case (state)
        IDLE: begin
          rdy_q <= 1'b1;
          if (start) begin
            rate_q   <= bus.i_code_rate;
            diff_q   <= bus.i_diff_en;
            len_q    <= len_eff;
            cnt      <= FRAME_W'(1);
            tail_cnt <= '0;
            if (len_eff == FRAME_W'(1)) begin
              state <= TAIL;
              rdy_q <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if ((cnt + 1'b1) == len_q) begin
              state <= TAIL;
              rdy_q <= 1'b0;
            end
          end
        end
        TAIL: begin
          tail_cnt <= tail_cnt + 1'b1;
          if (tail_last) begin
            state <= IDLE;
            rdy_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // frame start restarts the shift register from all-zero history
  always_comb begin
    v = {(in_sof ? {(K-1){1'b0}} : sr), in_d};
  end

  // tree holds all levels back to back: level l has W>>l bits
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr   <= '0;
      tree <= '0;
      for (int i = 0; i <= D; i++) side[i] <= '0;
      bus.o_vld      <= 1'b0;
      bus.o_sys      <= 1'b0;
      bus.o_par      <= 1'b0;
      bus.o_par_keep <= 1'b0;
      bus.o_sof      <= 1'b0;
      bus.o_eof      <= 1'b0;
    end else begin
      if (in_vld) sr <= v[K-2:0];
      tree[W-1:0] <= W'(v & POLY);
      for (int l = 1; l <= D; l++) begin
        for (int j = 0; j < (W >> l); j++) begin
          tree[2*W - 2*(W >> l) + j] <= tree[2*W - 2*(W >> (l-1)) + 2*j]
                                      ^ tree[2*W - 2*(W >> (l-1)) + 2*j + 1];
        end
      end
      side[0] <= {in_vld, in_d, in_sof, in_eof, in_keep};
      for (int i = 1; i <= D; i++) side[i] <= side[i-1];
      bus.o_vld      <= side[D].vld;
      bus.o_sys      <= side[D].vld & side[D].sys;
      bus.o_par      <= side[D].vld & tree[2*W-2];
      bus.o_par_keep <= side[D].vld & side[D].keep;
      bus.o_sof      <= side[D].vld & side[D].sof;
      bus.o_eof      <= side[D].vld & side[D].eof;
    end
  end

endmodule

// File: tb/tb_seq_conv_encoder_punct.sv
// Directed bench for seq_conv_encoder_punct: K=3 hand vectors plus a K=89 reference model.
module tb_seq_conv_encoder_punct;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seq_conv_encoder_punct_if #(.FRAME_W(16)) b3 ();
  seq_conv_encoder_punct_if #(.FRAME_W(16)) b89 ();

  seq_conv_encoder_punct #(.K(3), .POLY(3'b111), .FRAME_W(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(b3.slave));

  seq_conv_encoder_punct dut89 (
    .clk(clk), .reset_n(reset_n), .bus(b89.slave));

  typedef struct {
    logic sys;
    logic par;
    logic keep;
    logic sof;
    logic eof;
    int   t;
  } sym_t;

  localparam logic [88:0] P89 = 89'hD354E3267;

  sym_t q3[$];
  sym_t q89[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  logic [63:0] sys, par, keep, sof, eof;
  int          fc, ac, rl, ac89, i, guard;
  int          e_sys, e_par, e_keep, e_flag, ph;
  logic        bits [1000];
  logic [87:0] msr;
  logic [88:0] mv;
  logic        md, mprev, mpar, mkeep;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b3.o_vld === 1'b1)
      q3.push_back('{b3.o_sys, b3.o_par, b3.o_par_keep, b3.o_sof, b3.o_eof, cyc});
    if (b89.o_vld === 1'b1)
      q89.push_back('{b89.o_sys, b89.o_par, b89.o_par_keep, b89.o_sof, b89.o_eof, cyc});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // caller sits on a negedge; returns on the negedge where o_rdy is back high
  task automatic send3(input logic [1:0] rate, input logic diff, input int len,
                       input logic [63:0] data, input logic [3:0] vld_pat,
                       input int sw_at, input logic [1:0] sw_rate,
                       output int acc_cyc, output int rdy_low);
    int nbits;
    int n;
    int step;
    int g;
    nbits   = (len == 0) ? 1 : len;
    n       = 0;
    step    = 0;
    g       = 0;
    acc_cyc = -1;
    rdy_low = 0;
    b3.i_code_rate = rate;
    b3.i_diff_en   = diff;
    b3.i_frame_len = 16'(len);
    while (n < nbits && g < 400) begin
      if (n == sw_at) b3.i_code_rate = sw_rate;
      b3.i_vld  = vld_pat[step % 4];
      b3.i_data = data[n];
      if (b3.i_vld && b3.o_rdy === 1'b1) begin
        if (n == 0) acc_cyc = cyc + 1;
        n++;
      end
      step++;
      g++;
      @(negedge clk);
    end
    b3.i_vld = 1'b0;
    if (g >= 400) chk("send_timeout", 64'(n), 64'(nbits));
    while (b3.o_rdy !== 1'b1 && rdy_low < 50) begin
      rdy_low++;
      @(negedge clk);
    end
  endtask

  // pops n symbols, first symbol ends up as the MSB of each vector
  task automatic take3(input int n, output logic [63:0] s_sys, output logic [63:0] s_par,
                       output logic [63:0] s_keep, output logic [63:0] s_sof,
                       output logic [63:0] s_eof, output int first_t);
    sym_t s;
    s_sys = '0; s_par = '0; s_keep = '0; s_sof = '0; s_eof = '0;
    first_t = -1;
    for (int k = 0; k < n; k++) begin
      if (q3.size() == 0) break;
      s = q3.pop_front();
      if (k == 0) first_t = s.t;
      s_sys  = {s_sys[62:0], s.sys};
      s_par  = {s_par[62:0], s.par};
      s_keep = {s_keep[62:0], s.keep};
      s_sof  = {s_sof[62:0], s.sof};
      s_eof  = {s_eof[62:0], s.eof};
    end
  endtask

  initial begin
    reset_n = 1'b0;
    b3.i_vld = 0;  b3.i_data = 0;  b3.i_code_rate = 0;  b3.i_diff_en = 0;  b3.i_frame_len = 0;
    b89.i_vld = 0; b89.i_data = 0; b89.i_code_rate = 0; b89.i_diff_en = 0; b89.i_frame_len = 0;
    repeat (3) @(negedge clk);
    chk("rst_out3", {b3.o_rdy, b3.o_vld, b3.o_sys, b3.o_par, b3.o_par_keep, b3.o_sof, b3.o_eof}, 0);
    chk("rst_out89", {b89.o_rdy, b89.o_vld, b89.o_sys, b89.o_par, b89.o_par_keep, b89.o_sof, b89.o_eof}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", b3.o_rdy, 1);

    // rate 1/2, data 1,0,1,1
    send3(2'd0, 1'b0, 4, 64'b1101, 4'b1111, -1, 2'd0, ac, rl);
    chk("basic_rdy_low", rl, 2);
    repeat (12) @(negedge clk);
    chk("basic_n", q3.size(), 6);
    take3(6, sys, par, keep, sof, eof, fc);
    chk("basic_sys", sys, 6'b101100);
    chk("basic_par", par, 6'b110001);
    chk("basic_keep", keep, 6'b111111);
    chk("basic_sof", sof, 6'b100000);
    chk("basic_eof", eof, 6'b000001);
    chk("basic_lat", fc - ac, 4);

    // differential, data 1,1,1,1
    send3(2'd0, 1'b1, 4, 64'b1111, 4'b1111, -1, 2'd0, ac, rl);
    repeat (12) @(negedge clk);
    chk("diff_n", q3.size(), 6);
    take3(6, sys, par, keep, sof, eof, fc);
    chk("diff_sys", sys, 6'b101000);
    chk("diff_par", par, 6'b110110);

    // rate 3/4, 7 bits + 2 tail
    send3(2'd2, 1'b0, 7, 64'b1001011, 4'b1111, -1, 2'd0, ac, rl);
    repeat (12) @(negedge clk);
    chk("p34_n", q3.size(), 9);
    take3(9, sys, par, keep, sof, eof, fc);
    chk("p34_keep", keep, 9'b001001001);
    chk("p34_eof", eof, 9'b000000001);

    // gapped frame at 2/3 with a mid-frame rate change, then an immediate 3/4 frame
    send3(2'd1, 1'b0, 4, 64'b1101, 4'b1001, 2, 2'd2, ac, rl);
    send3(2'd2, 1'b0, 4, 64'b1101, 4'b1111, -1, 2'd0, ac, rl);
    repeat (12) @(negedge clk);
    chk("gap_n", q3.size(), 12);
    take3(6, sys, par, keep, sof, eof, fc);
    chk("gap_sys", sys, 6'b101100);
    chk("gap_par", par, 6'b110001);
    chk("gap_keep", keep, 6'b010101);
    take3(6, sys, par, keep, sof, eof, fc);
    chk("next_sys", sys, 6'b101100);
    chk("next_par", par, 6'b110001);
    chk("next_keep", keep, 6'b001001);
    chk("next_sof", sof, 6'b100000);
    chk("next_lat", fc - ac, 4);

    // 7/8 on a 6-symbol frame: only the eof symbol keeps parity
    send3(2'd3, 1'b0, 4, 64'b1101, 4'b1111, -1, 2'd0, ac, rl);
    repeat (12) @(negedge clk);
    take3(6, sys, par, keep, sof, eof, fc);
    chk("p78_keep", keep, 6'b000001);
    chk("p78_par", par, 6'b110001);

    // frame_len 0 behaves as a single bit
    send3(2'd0, 1'b0, 0, 64'b1, 4'b1111, -1, 2'd0, ac, rl);
    repeat (12) @(negedge clk);
    chk("len0_n", q3.size(), 3);
    take3(3, sys, par, keep, sof, eof, fc);
    chk("len0_sys", sys, 3'b100);
    chk("len0_par", par, 3'b111);
    chk("len0_eof", eof, 3'b001);

    // reset after the second accept
    b3.i_code_rate = 0; b3.i_diff_en = 0; b3.i_frame_len = 16'd4;
    b3.i_vld = 1'b1; b3.i_data = 1'b1;
    @(negedge clk);
    b3.i_data = 1'b0;
    @(negedge clk);
    b3.i_vld = 1'b0;
    reset_n  = 1'b0;
    @(negedge clk);
    chk("midrst_out", {b3.o_rdy, b3.o_vld, b3.o_sys, b3.o_par, b3.o_par_keep, b3.o_sof, b3.o_eof}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", b3.o_rdy, 1);
    repeat (12) @(negedge clk);
    chk("midrst_nosym", q3.size(), 0);
    send3(2'd0, 1'b0, 4, 64'b1101, 4'b1111, -1, 2'd0, ac, rl);
    repeat (12) @(negedge clk);
    take3(6, sys, par, keep, sof, eof, fc);
    chk("midrst_sys", sys, 6'b101100);
    chk("midrst_par", par, 6'b110001);
    chk("midrst_sof", sof, 6'b100000);
    chk("midrst_eof", eof, 6'b000001);

    // default K=89: 1000 random bits, diff on, rate 7/8
    for (int k = 0; k < 1000; k++) bits[k] = 1'($urandom_range(0, 1));
    b89.i_code_rate = 2'd3; b89.i_diff_en = 1'b1; b89.i_frame_len = 16'd1000;
    i = 0; guard = 0; ac89 = -1;
    while (i < 1000 && guard < 3000) begin
      b89.i_vld  = 1'b1;
      b89.i_data = bits[i];
      if (b89.o_rdy === 1'b1) begin
        if (i == 0) ac89 = cyc + 1;
        i++;
      end
      guard++;
      @(negedge clk);
    end
    b89.i_vld = 1'b0;
    if (guard >= 3000) chk("k89_send_timeout", i, 1000);
    repeat (120) @(negedge clk);
    chk("k89_n", q89.size(), 1088);

    msr = '0; mprev = 1'b0; ph = 0;
    e_sys = 0; e_par = 0; e_keep = 0; e_flag = 0;
    for (int k = 0; k < 1088 && k < q89.size(); k++) begin
      md = (k < 1000) ? (bits[k] ^ mprev) : 1'b0;
      if (k < 1000) mprev = md;
      mv    = {msr, md};
      mpar  = ^(mv & P89);
      msr   = mv[87:0];
      mkeep = (ph == 6) || (k == 1087);
      ph    = (ph == 6) ? 0 : ph + 1;
      if (q89[k].sys !== md)    e_sys++;
      if (q89[k].par !== mpar)  e_par++;
      if (q89[k].keep !== mkeep) e_keep++;
      if (q89[k].sof !== (k == 0) || q89[k].eof !== (k == 1087)) e_flag++;
    end
    chk("k89_sys_errs", e_sys, 0);
    chk("k89_par_errs", e_par, 0);
    chk("k89_keep_errs", e_keep, 0);
    chk("k89_flag_errs", e_flag, 0);
    if (q89.size() > 0) begin
      chk("k89_lat", q89[0].t - ac89, 9);
      chk("k89_contig", q89[q89.size()-1].t - q89[0].t, 1087);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_conv_encoder_punct.md
# seq_conv_encoder_punct

Parametrised, frame-based systematic convolutional encoder for the Fano decoder test chain. It is the next generation of the sequential encoder: shift-register length and generator polynomial are parameters, and it adds a valid/ready handshake, per-frame latching of rate and differential mode, automatic zero-tail termination, and systematic puncturing for rates 1/2, 2/3, 3/4 and 7/8. It sits between the bit source and the modulator/channel model. Its output is one systematic bit plus one parity bit with a keep flag per coded symbol.

## Interface
- K, 89: encoder register length including the current bit. Legal range 3..128.
- POLY, 89'hD354E3267: K-bit generator; bit 0 taps the current bit, bit i taps the bit i symbols earlier.
- FRAME_W, 16: width of the frame-length field.
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- i_code_rate  in  2  code rate: 0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = 7/8. Latched at frame start.
- i_diff_en  in  1  differential pre-coding enable. Latched at frame start.
- i_frame_len  in  FRAME_W  information bits per frame; 0 is treated as 1. Latched at frame start.
- i_vld  in  1  input bit valid.
- i_data  in  1  information bit.
- o_rdy  out  1  encoder accepts i_data this cycle.
- o_vld  out  1  coded symbol valid.
- o_sys  out  1  systematic (pre-coded) bit.
- o_par  out  1  parity bit.
- o_par_keep  out  1  parity survives puncturing; the receiver discards o_par when this is 0.
- o_sof  out  1  first symbol of a frame.
- o_eof  out  1  last tail symbol of a frame.

## Operation
- Handshake: a bit is accepted on a rising edge with i_vld & o_rdy. Gaps in i_vld are legal; encoder state holds during gaps.
- FSM states: IDLE, DATA, TAIL.
  - IDLE: o_rdy=1. The first accept latches rate, diff_en and frame_len, clears the pre-coder, shift register and puncture counter, encodes the bit with o_sof, then moves to DATA (or to TAIL if frame_len<=1).
  - DATA: o_rdy=1. Each accept increments the bit counter. The accept with count == frame_len moves to TAIL.
  - TAIL: o_rdy=0. Injects K-1 zero bits, one per cycle with no gaps. The pre-coder is bypassed so the injected bits are raw zeros. The last injected bit carries o_eof, and the FSM returns to IDLE on the next cycle.
- Pre-coder: d_n = x_n ^ d_(n-1) when diff_en=1, otherwise d_n = x_n. d_(-1) = 0 at every frame start.
- Parity:
  - v = {sr[K-2:0], d_n}; parity = XOR-reduce(v & POLY); then sr <= v.
  - o_sys = d_n.
- Puncturing:
  - Counter p runs 0..k-1 per coded symbol, including tail symbols, with k = 1/2/3/7 for rate codes 0..3.
  - o_par_keep = (p == k-1), and is forced to 1 on the o_eof symbol.
  - For rate 1/2, o_par_keep is always 1.
- Config inputs are sampled only on the frame-start accept. Changes mid-frame take effect at the next frame.
- Reset mid-frame: the FSM returns to IDLE, all pipeline contents are discarded, and no o_eof is produced for the aborted frame.

## Timing
- The parity XOR tree is fully registered with D = ceil(log2 K) levels.
- Latency LAT = D+2 cycles, measured from the accepting edge (or tail-inject edge) to the o_vld edge. K=89 gives LAT=9; K=3 gives LAT=4.
- o_sys, o_sof, o_eof and o_par_keep are delayed to match o_par exactly.
- Throughput is 1 symbol per cycle. The TAIL phase takes exactly K-1 cycles. A new frame may start on the first cycle after TAIL ends; no idle gap is required beyond that.
- Reset values: o_rdy=0 while reset_n=0 and 1 on the first cycle after; o_vld=0, o_sys=0, o_par=0, o_par_keep=0, o_sof=0, o_eof=0.
- A reset asserted at the same edge as an accept takes priority; the bit is dropped.

## Test plan
All scenarios use K=3 and POLY=3'b111 unless stated.
- Basic rate 1/2:
  - Stimulus: diff off, frame_len=4, data 1,0,1,1 back-to-back.
  - Response: 6 symbols, the first 4 cycles after the first accept.
  - o_sys 1,0,1,1,0,0; o_par 1,1,0,0,0,1; keep all 1.
  - o_sof on symbol 1, o_eof on symbol 6; o_rdy low for 2 cycles.
- Differential:
  - Stimulus: diff on, frame_len=4, data 1,1,1,1.
  - Response: o_sys 1,0,1,0,0,0; o_par 1,1,0,1,1,0.
- Puncture 3/4:
  - Stimulus: rate=2, frame_len=7, any data.
  - Response: o_par_keep=1 only on symbols 3, 6 and 9; 9 is also o_eof.
- Gaps and latched config:
  - Stimulus: i_vld toggles 1,0,0,1,... through a frame; change i_code_rate mid-frame.
  - Response: output bits match the gap-free run; the new rate applies only from the next o_sof.
- Reset mid-frame:
  - Stimulus: assert reset_n=0 after the 2nd accept.
  - Response: all outputs 0 within 1 cycle, no o_eof; the next frame's output is identical to a fresh-start run.
- Default parameters:
  - Stimulus: K=89, POLY default, 1000 random bits at rate 7/8, compared against a software model.
  - Response: bit-exact match with LAT=9.
